pattern_loader: RTL and testbench
=================================

Name: pattern_loader

Overview:
- Serial master that fills the 32x8 pattern buffer over its serial shift interface.
- Accepts a frame of buffer_size bytes on a valid/ready byte stream and serialises them onto ssel/sin, MSB first.
- At the same time, captures the buffer's previous contents from sout as readback bytes.
- Sits between the host/config logic and the pattern buffer; both blocks run on the same sclk.

Parameters:
buffer_width, 8, bits per pattern entry (bits per byte shifted)
buffer_size, 32, entries per frame (bytes per load)

Ports:
sclk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a frame load
abort  input  1  terminate current frame
in_data  input  buffer_width  next byte of frame
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
ssel  output  1  shift enable to pattern buffer (registered)
sin  output  1  serial data to pattern buffer (registered)
sout  input  1  serial data from pattern buffer (MSB of last entry)
rb_data  output  buffer_width  readback byte
rb_valid  output  1  rb_data valid, one-cycle pulse
busy  output  1  frame in progress
done  output  1  one-cycle pulse: full frame shifted

Behaviour:
- One clock (sclk). Reset is synchronous and active-high on rst.
- Reset values: ssel=0, sin=0, in_ready=0, rb_data=0, rb_valid=0, busy=0, done=0. State=IDLE, counters=0.
- Frame ordering: the first accepted byte lands in entry buffer_size-1; the last lands in entry 0. Each byte is shifted MSB first.
- State IDLE:
  - start=1 -> WAIT; busy=1 from the next cycle.
  - Byte input is ignored in IDLE.
- State WAIT (shift register empty): in_ready=1.
  - On in_valid&in_ready: load the shift register and set sin=in_data[7], ssel=1. Go to SHIFT with bit counter 0.
- State SHIFT:
  - ssel=1 every cycle; sin advances one bit per edge. The buffer samples each bit on the following edge.
  - in_ready=1 combinationally only when the bit counter=buffer_width-1 and bytes remaining>0.
  - Accept on that edge -> next byte follows with no gap; 32 back-to-back bytes give exactly 256 consecutive ssel cycles.
  - Last bit, no byte accepted, bytes remaining>0 -> WAIT; ssel=0; the buffer holds.
  - Last bit of the final byte -> DONE.
- State DONE: ssel=0, busy=0, done=1 for one cycle -> IDLE.
- Byte counter: width clog2(buffer_size), counts accepted bytes; a frame is complete after exactly buffer_size bytes.
- Readback:
  - On every edge where registered ssel=1, sample sout into a capture register, MSB first.
  - After the 8th sample, rb_data shows the captured byte and rb_valid=1 for one cycle. It is coincident with the edge after the byte's last shift.
  - Readback order is old entry 31 down to entry 0.
- abort=1 in any non-IDLE state:
  - Next cycle: ssel=0, in_ready=0, busy=0, no done, no rb_valid for a partial byte. Go to IDLE.
  - The buffer keeps its partially shifted contents.
- Simultaneous events:
  - abort has priority over a byte accept on the same edge; the byte is not consumed.
  - start while busy is ignored.
  - rst has priority over everything.
- rst mid-frame: outputs return to reset values on the next edge; the buffer contents are left partial.
- in_ready is never asserted in IDLE or DONE.

Optional Feature:
- Macro: PATTERN_LOADER_READBACK_EN.
- Defined: sout capture and rb_data/rb_valid behave as above.
- Undefined: no capture logic; rb_data tied 0, rb_valid tied 0; sout unused. All other behaviour is identical.

Test Plan:
- Reset, start, 32 back-to-back bytes 8'h00..8'h1F with in_valid held -> ssel high exactly 256 consecutive cycles; buffer entry k = 31-k (entry 31 = 8'h00, entry 0 = 8'h1F); done one pulse; busy 0 afterwards.
- Preload buffer with entry k = 8'hA0+k, then load any frame -> 32 rb_valid pulses, rb_data sequence 8'hBF, 8'hBE, ..., 8'hA0.
- in_valid dropped for 5 cycles after byte 10 -> ssel low exactly those cycles; final buffer contents identical to the gapless case.
- abort asserted during bit 3 of byte 7 -> ssel=0 next cycle, busy=0, no done, no further rb_valid; a subsequent full frame loads correctly.
- start pulsed while busy, and in_valid in IDLE -> no effect on byte count, ssel or in_ready.
- Build without PATTERN_LOADER_READBACK_EN, run the first scenario -> identical ssel/sin trace; rb_valid never asserts.

Source files
------------

// File: rtl/pattern_loader.sv
// Serial master that streams a frame of bytes into the 32x8 pattern buffer over ssel/sin, MSB first.
// Define PATTERN_LOADER_READBACK_EN to capture the buffer's previous contents from sout as readback bytes.
`timescale 1ns/1ps
module pattern_loader #(
  parameter int unsigned buffer_width = 8,
  parameter int unsigned buffer_size  = 32
) (
  input  logic                    i_sclk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [buffer_width-1:0] i_in_data,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  output logic                    o_ssel,
  output logic                    o_sin,
  input  logic                    i_sout,
  output logic [buffer_width-1:0] o_rb_data,
  output logic                    o_rb_valid,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned BW = $clog2(buffer_width);
  localparam int unsigned CW = $clog2(buffer_size);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BW-1:0]           r_bit_cnt;
  logic [CW-1:0]           r_byte_cnt;
  logic                    r_final;
  logic [buffer_width-1:0] r_shreg;
  logic                    r_ssel;
  logic                    r_sin;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_abort;
  logic                    w_ready;
  logic                    w_load;
  logic                    w_shift;
  logic                    w_ssel_nxt;

  assign w_abort = i_abort && (r_state != S_IDLE);

  // Next-state and handshake decode; abort overrides any accept on the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_ssel_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_ready = 1'b1;
        if (i_in_valid) begin
          w_load      = 1'b1;
          w_ssel_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == BW'(buffer_width - 1)) begin
          w_ready = !r_final;
          if (!r_final && i_in_valid) begin
            w_load     = 1'b1;
            w_ssel_nxt = 1'b1;
          end else if (r_final) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_shift    = 1'b1;
          w_ssel_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_ready     = 1'b0;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_ssel_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_final    <= 1'b0;
      r_shreg    <= '0;
      r_ssel     <= 1'b0;
      r_sin      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ssel  <= w_ssel_nxt;
      r_busy  <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_IDLE) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_final    <= 1'b0;
      end else if (w_load) begin
        r_shreg    <= {i_in_data[buffer_width-2:0], 1'b0};
        r_sin      <= i_in_data[buffer_width-1];
        r_bit_cnt  <= '0;
        r_byte_cnt <= r_byte_cnt + CW'(1);
        r_final    <= (r_byte_cnt == CW'(buffer_size - 1));
      end else if (w_shift) begin
        r_sin     <= r_shreg[buffer_width-1];
        r_shreg   <= r_shreg << 1;
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  assign o_in_ready = w_ready && !i_rst;
  assign o_ssel     = r_ssel;
  assign o_sin      = r_sin;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

`ifdef PATTERN_LOADER_READBACK_EN
  logic [buffer_width-1:0] r_cap;
  logic [BW-1:0]           r_rb_cnt;
  logic [buffer_width-1:0] r_rb_data;
  logic                    r_rb_valid;

  // sout reflects the old entry 31 MSB before each shift; a partial byte is dropped on abort
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_cap      <= '0;
      r_rb_cnt   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_abort) begin
        r_rb_cnt <= '0;
      end else if (r_ssel) begin
        r_cap <= {r_cap[buffer_width-2:0], i_sout};
        if (r_rb_cnt == BW'(buffer_width - 1)) begin
          r_rb_cnt   <= '0;
          r_rb_data  <= {r_cap[buffer_width-2:0], i_sout};
          r_rb_valid <= 1'b1;
        end else begin
          r_rb_cnt <= r_rb_cnt + BW'(1);
        end
      end
    end
  end

  assign o_rb_data  = r_rb_data;
  assign o_rb_valid = r_rb_valid;
`else
  logic w_unused_sout;
  assign w_unused_sout = i_sout;
  assign o_rb_data     = '0;
  assign o_rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader with a behavioural 32x8 shift-chain buffer model on ssel/sin/sout.
`timescale 1ns/1ps
module tb_pattern_loader;

  logic       i_sclk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [7:0] i_in_data = 8'h00;
  logic       i_in_valid = 1'b0;
  logic       o_in_ready;
  logic       o_ssel;
  logic       o_sin;
  logic       i_sout;
  logic [7:0] o_rb_data;
  logic       o_rb_valid;
  logic       o_busy;
  logic       o_done;

  int n_pass = 0;
  int n_total = 0;

  pattern_loader #(.buffer_width(8), .buffer_size(32)) dut (
    .i_sclk(i_sclk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_ssel(o_ssel), .o_sin(o_sin), .i_sout(i_sout),
    .o_rb_data(o_rb_data), .o_rb_valid(o_rb_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_sclk = ~i_sclk;

  // Buffer model: {entry31..entry0} as one chain, shifted left on each ssel edge
  logic [255:0] buf_vec = '0;
  logic [255:0] preload_val = '0;
  logic         preload_req = 1'b0;
  logic         clr_req = 1'b0;
  assign i_sout = buf_vec[255];

  int   cyc = 0;
  int   ssel_cnt = 0;
  int   runs = 0;
  int   first_ss = 0;
  int   last_ss = 0;
  int   done_cnt = 0;
  int   rb_n = 0;
  logic prev_ssel = 1'b0;
  logic [7:0] rb_q [64];

  always @(posedge i_sclk) begin
    cyc <= cyc + 1;
    if (preload_req) buf_vec <= preload_val;
    else if (o_ssel) buf_vec <= {buf_vec[254:0], o_sin};
    if (clr_req) begin
      ssel_cnt <= 0; runs <= 0; first_ss <= 0; last_ss <= 0;
      done_cnt <= 0; rb_n <= 0; prev_ssel <= 1'b0;
    end else begin
      prev_ssel <= o_ssel;
      if (o_ssel) begin
        if (ssel_cnt == 0) first_ss <= cyc;
        last_ss  <= cyc;
        ssel_cnt <= ssel_cnt + 1;
        if (!prev_ssel) runs <= runs + 1;
      end
      if (o_done) done_cnt <= done_cnt + 1;
      if (o_rb_valid) begin
        if (rb_n < 64) rb_q[rb_n] <= o_rb_data;
        rb_n <= rb_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic prep(input logic [7:0] fill, input bit ramp);
    for (int k = 0; k < 32; k++)
      preload_val[k*8 +: 8] = ramp ? 8'(8'hA0 + 8'(k)) : fill;
    preload_req = 1'b1;
    clr_req = 1'b1;
    tick();
    preload_req = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic check_buf(input string tag, input logic [7:0] base);
    logic [7:0] e;
    for (int k = 0; k < 32; k++) begin
      e = buf_vec[k*8 +: 8];
      chk($sformatf("%s[%0d]", tag, k), 32'(e), 32'(8'(base + 8'(31 - k))));
    end
  endtask

  // Streams bytes base..base+31; optional stall after byte gap_after, abort in byte abort_byte, start pulse at start_at
  task automatic send_frame(input logic [7:0] base, input int gap_after, input int abort_byte, input int start_at);
    int budget;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("ready_in_wait", 32'(o_in_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      budget = 0;
      i_in_data  = 8'(base + 8'(i));
      i_in_valid = 1'b1;
      i_start    = (i == start_at);
      while (!o_in_ready) begin
        tick();
        i_start = 1'b0;
        budget++;
        if (budget > 40) begin
          chk($sformatf("ready_timeout_byte%0d", i), 32'd0, 32'd1);
          i_in_valid = 1'b0;
          return;
        end
      end
      tick();
      i_start = 1'b0;
      if (i == gap_after) begin
        i_in_valid = 1'b0;
        repeat (12) tick();
      end
      if (i == abort_byte) begin
        i_in_valid = 1'b0;
        repeat (3) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        return;
      end
    end
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(o_done), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_ssel_cnt"}, 32'(ssel_cnt), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    i_rst = 1'b0;
    chk("rst_ssel", 32'(o_ssel), 32'd0);
    chk("rst_sin", 32'(o_sin), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_rb_data", 32'(o_rb_data), 32'd0);
    chk("rst_rb_valid", 32'(o_rb_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);

    // Byte input in IDLE is ignored
    prep(8'h00, 1'b1);
    i_in_data  = 8'h77;
    i_in_valid = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_in_ready", 32'(o_in_ready), 32'd0);
    end
    chk("idle_ssel_cnt", 32'(ssel_cnt), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    i_in_valid = 1'b0;

    // Gapless frame 00..1F over a ramp preload A0+k
    prep(8'h00, 1'b1);
    send_frame(8'h00, -1, -1, -1);
    wait_done("f1");
    chk("f1_runs", 32'(runs), 32'd1);
    chk("f1_span", 32'(last_ss - first_ss + 1), 32'd256);
    check_buf("f1_buf", 8'h00);
`ifdef PATTERN_LOADER_READBACK_EN
    chk("f1_rb_n", 32'(rb_n), 32'd32);
    for (int i = 0; i < 32; i++)
      chk($sformatf("f1_rb[%0d]", i), 32'(rb_q[i]), 32'(8'(8'hBF - 8'(i))));
`else
    chk("f1_rb_n", 32'(rb_n), 32'd0);
`endif

    // Stall after byte 10: ssel drops for exactly 5 cycles, contents unchanged vs gapless
    prep(8'h55, 1'b0);
    send_frame(8'h00, 10, -1, -1);
    wait_done("f2");
    chk("f2_runs", 32'(runs), 32'd2);
    chk("f2_span", 32'(last_ss - first_ss + 1), 32'd261);
    check_buf("f2_buf", 8'h00);
`ifdef PATTERN_LOADER_READBACK_EN
    chk("f2_rb_n", 32'(rb_n), 32'd32);
    chk("f2_rb0", 32'(rb_q[0]), 32'h55);
`else
    chk("f2_rb_n", 32'(rb_n), 32'd0);
`endif

    // Abort during bit 3 of byte 7
    prep(8'h00, 1'b1);
    send_frame(8'h60, -1, 7, -1);
    chk("ab_ssel", 32'(o_ssel), 32'd0);
    chk("ab_busy", 32'(o_busy), 32'd0);
    chk("ab_in_ready", 32'(o_in_ready), 32'd0);
    repeat (10) tick();
    chk("ab_done_cnt", 32'(done_cnt), 32'd0);
    chk("ab_ssel_cnt", 32'(ssel_cnt), 32'd60);
    chk("ab_busy_later", 32'(o_busy), 32'd0);
`ifdef PATTERN_LOADER_READBACK_EN
    chk("ab_rb_n", 32'(rb_n), 32'd7);
`else
    chk("ab_rb_n", 32'(rb_n), 32'd0);
`endif

    // Full frame after abort, with a stray start pulse mid-frame
    prep(8'h00, 1'b1);
    send_frame(8'h80, -1, -1, 12);
    wait_done("f4");
    chk("f4_runs", 32'(runs), 32'd1);
    check_buf("f4_buf", 8'h80);
    repeat (3) tick();
    chk("f4_idle_busy", 32'(o_busy), 32'd0);
    chk("f4_idle_ssel", 32'(o_ssel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
